// File: rtl/multicart_mapper.sv
// Multicart NES mapper: an address-latched outer bank register with a one-shot lock,
// a data-written inner CHR/PRG sub-bank register, and a CPU-cycle IRQ down-counter.
module multicart_mapper #(
  parameter int PRG_BITS       = 3,
  parameter int CHR_OUTER_BITS = 2,
  parameter int CHR_INNER_BITS = 2,
  parameter logic [4:0] OUTER_BASE = 5'b01100,
  parameter int IRQ_BITS       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [31:0] flags,
  input  logic [15:0] prg_ain,
  input  logic        prg_read,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  output logic [21:0] prg_aout,
  output logic        prg_allow,
  input  logic [13:0] chr_ain,
  output logic [21:0] chr_aout,
  output logic        chr_allow,
  output logic        vram_a10,
  output logic        vram_ce,
  output logic        irq
);

  localparam int CO_LSB   = PRG_BITS;
  localparam int MIR_LSB  = PRG_BITS + CHR_OUTER_BITS;
  localparam int MODE_BIT = MIR_LSB + 2;
  localparam int LOCK_BIT = MODE_BIT + 1;

  logic [PRG_BITS-1:0]       prg_bank;
  logic [CHR_OUTER_BITS-1:0] chr_outer;
  logic [CHR_INNER_BITS-1:0] chr_inner;
  logic [1:0]                mirror;
  logic                      prg_mode;
  logic                      lock;
  logic                      prg_sub;
  logic [IRQ_BITS-1:0]       latch;
  logic [IRQ_BITS-1:0]       latch_next;
  logic [IRQ_BITS-1:0]       counter;
  logic                      irq_en;

  logic wr, outer_hit, inner_hit, latch_hit, ctrl_hit;

  assign wr        = ce && prg_write;
  assign outer_hit = wr && (prg_ain[15:11] == OUTER_BASE) && !lock;
  assign inner_hit = wr && (prg_ain[15:14] == 2'b10) && prg_bank[PRG_BITS-1];
  assign latch_hit = wr && (prg_ain[15:13] == 3'b110);
  assign ctrl_hit  = wr && (prg_ain[15:13] == 3'b111);

  // The high latch byte only carries the bits above 7 that exist for this IRQ width.
  always_comb begin
    latch_next = latch;
    if (!prg_ain[0]) begin
      latch_next[7:0] = prg_din;
    end else begin
      for (int i = 8; i < IRQ_BITS; i++) latch_next[i] = prg_din[i-8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prg_bank  <= '0;
      chr_outer <= '0;
      chr_inner <= '0;
      mirror    <= '0;
      prg_mode  <= 1'b0;
      lock      <= 1'b0;
      prg_sub   <= 1'b0;
      latch     <= '0;
      counter   <= '0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
    end else if (ce) begin
      if (outer_hit) begin
        prg_bank  <= prg_ain[PRG_BITS-1:0];
        chr_outer <= prg_ain[CO_LSB +: CHR_OUTER_BITS];
        mirror    <= prg_ain[MIR_LSB +: 2];
        prg_mode  <= prg_ain[MODE_BIT];
        lock      <= prg_ain[LOCK_BIT];
      end
      if (inner_hit) begin
        chr_inner <= prg_din[CHR_INNER_BITS-1:0];
        prg_sub   <= prg_din[7];
      end
      if (latch_hit) latch <= latch_next;
      // An acknowledge wins over a terminal count landing in the same cycle.
      if (ctrl_hit) begin
        irq_en  <= prg_din[0];
        counter <= latch;
        irq     <= 1'b0;
      end else if (irq_en) begin
        if (counter == '0) begin
          irq     <= 1'b1;
          counter <= latch;
        end else begin
          counter <= counter - IRQ_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    if (prg_mode) prg_aout = 22'({prg_bank, prg_sub, prg_ain[13:0]});
    else          prg_aout = 22'({prg_bank, prg_ain[14:0]});
    chr_aout = {1'b1, 21'({chr_outer, chr_inner, chr_ain[12:0]})};
    case (mirror)
      2'b00:   vram_a10 = chr_ain[10];
      2'b01:   vram_a10 = chr_ain[11];
      2'b10:   vram_a10 = 1'b0;
      default: vram_a10 = 1'b1;
    endcase
  end

  assign prg_allow = prg_ain[15] && !prg_write;
  assign chr_allow = flags[15];
  assign vram_ce   = chr_ain[13];

  logic unused_inputs;
  assign unused_inputs = &{1'b0, prg_read, flags, prg_din, prg_ain, chr_ain};

endmodule

// File: tb/tb_multicart_mapper.sv
// Randomized bench for multicart_mapper: an arithmetic model of the bank/IRQ rules
// is checked against the DUT every cycle, plus directed literal scenarios.
module tb_multicart_mapper;

  logic        clk = 1'b0;
  logic        reset, ce, prg_read, prg_write;
  logic [31:0] flags;
  logic [15:0] prg_ain;
  logic [7:0]  prg_din;
  logic [21:0] prg_aout, chr_aout;
  logic [13:0] chr_ain;
  logic        prg_allow, chr_allow, vram_a10, vram_ce, irq;

  always #5 clk = ~clk;

  multicart_mapper dut (
    .clk(clk), .reset(reset), .ce(ce), .flags(flags),
    .prg_ain(prg_ain), .prg_read(prg_read), .prg_write(prg_write), .prg_din(prg_din),
    .prg_aout(prg_aout), .prg_allow(prg_allow),
    .chr_ain(chr_ain), .chr_aout(chr_aout), .chr_allow(chr_allow),
    .vram_a10(vram_a10), .vram_ce(vram_ce), .irq(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_bank, m_outer, m_inner, m_mirror, m_mode, m_lock, m_sub;
  int m_latch, m_cnt, m_en, m_irq;
  bit m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int ai, ci, e_prg, e_chr, e_a10;
    ai = int'(prg_ain);
    ci = int'(chr_ain);
    if (m_mode == 0) e_prg = m_bank * 32768 + ai % 32768;
    else             e_prg = m_bank * 32768 + m_sub * 16384 + ai % 16384;
    e_chr = 2097152 + (m_outer * 4 + m_inner) * 8192 + ci % 8192;
    case (m_mirror)
      0:       e_a10 = (ci / 1024) % 2;
      1:       e_a10 = (ci / 2048) % 2;
      2:       e_a10 = 0;
      default: e_a10 = 1;
    endcase
    chk("prg_aout", 32'(prg_aout), 32'(e_prg));
    chk("chr_aout", 32'(chr_aout), 32'(e_chr));
    chk("vram_a10", 32'(vram_a10), 32'(e_a10));
    chk("prg_allow", 32'(prg_allow), 32'((ai >= 32768) && !prg_write));
    chk("chr_allow", 32'(chr_allow), 32'(flags[15]));
    chk("vram_ce", 32'(vram_ce), 32'((ci / 8192) % 2));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic model_step(input bit rst, input bit c, input bit w, input int ai, input int di);
    int old_bank, old_latch;
    old_bank  = m_bank;
    old_latch = m_latch;
    if (rst) begin
      m_bank = 0; m_outer = 0; m_inner = 0; m_mirror = 0; m_mode = 0; m_lock = 0; m_sub = 0;
      m_latch = 0; m_cnt = 0; m_en = 0; m_irq = 0;
      m_valid = 1'b1;
    end else if (c) begin
      if (w && ai / 2048 == 12 && m_lock == 0) begin
        m_bank   = ai % 8;
        m_outer  = (ai / 8) % 4;
        m_mirror = (ai / 32) % 4;
        m_mode   = (ai / 128) % 2;
        m_lock   = (ai / 256) % 2;
      end
      if (w && ai / 16384 == 2 && old_bank >= 4) begin
        m_inner = di % 4;
        m_sub   = di / 128;
      end
      if (w && ai / 8192 == 6) begin
        if (ai % 2 == 1) m_latch = old_latch % 256 + di * 256;
        else             m_latch = old_latch - old_latch % 256 + di;
      end
      if (w && ai / 8192 == 7) begin
        m_en = di % 2; m_cnt = old_latch; m_irq = 0;
      end else if (m_en == 1) begin
        if (m_cnt == 0) begin m_irq = 1; m_cnt = old_latch; end
        else m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic do_cycle(input bit rst, input bit c, input bit w, input logic [15:0] a,
                          input logic [7:0] d, input logic [13:0] ca, input logic [31:0] fl);
    @(negedge clk);
    reset = rst; ce = c; prg_write = w; prg_read = !w;
    prg_ain = a; prg_din = d; chr_ain = ca; flags = fl;
    #1;
    if (m_valid) compare_model();
    model_step(rst, c, w, int'(a), int'(d));
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    do_cycle(1'b0, 1'b1, 1'b1, a, d, 14'h0, 32'h0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [13:0] ca);
    do_cycle(1'b0, 1'b1, 1'b0, a, 8'h0, ca, 32'h0000_8000);
  endtask

  task automatic idle(input bit c);
    do_cycle(1'b0, c, 1'b0, 16'h0000, 8'h0, 14'h0, 32'h0);
  endtask

  task automatic rst_cycle();
    do_cycle(1'b1, 1'b1, 1'b0, 16'h0000, 8'h0, 14'h0, 32'h0);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    bit w;
    rst_cycle();
    rst_cycle();

    rd(16'h8123, 14'h1ABC);
    chk("reset_prg", 32'(prg_aout), 32'h000123);
    chk("reset_chr", 32'(chr_aout), 32'h201ABC);
    chk("reset_a10", 32'(vram_a10), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);

    wr(16'h600D, 8'h00);
    wr(16'h8000, 8'h03);
    rd(16'h8000, 14'h0005);
    chk("inner_chr", 32'(chr_aout), 32'h20E005);
    chk("bank5_prg", 32'(prg_aout), 32'h028000);
    wr(16'h600A, 8'h00);
    wr(16'h8000, 8'h00);
    rd(16'h8000, 14'h0005);
    chk("inner_gated_chr", 32'(chr_aout), 32'h20E005);

    wr(16'h6007, 8'h00);
    wr(16'h8000, 8'h80);
    wr(16'h60E3, 8'h00);
    rd(16'hC010, 14'h0400);
    chk("mode16_prg", 32'(prg_aout), 32'h01C010);
    chk("mirror_b_a10", 32'(vram_a10), 32'h1);

    wr(16'h6101, 8'h00);
    wr(16'h6006, 8'h00);
    rd(16'h8000, 14'h0);
    chk("locked_prg", 32'(prg_aout), 32'h008000);
    rst_cycle();
    wr(16'h6006, 8'h00);
    rd(16'h8000, 14'h0);
    chk("unlocked_prg", 32'(prg_aout), 32'h030000);

    wr(16'hC000, 8'h03);
    wr(16'hC001, 8'h00);
    wr(16'hE000, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      idle(1'b1);
      chk("irq_period1", 32'(irq), 32'(k >= 5));
    end
    wr(16'hE000, 8'h01);
    for (int k = 1; k <= 6; k++) begin
      idle(1'b1);
      chk("irq_period2", 32'(irq), 32'(k >= 5));
    end
    wr(16'hE000, 8'h01);
    idle(1'b1); idle(1'b1); idle(1'b1);
    wr(16'hE000, 8'h01);
    idle(1'b1);
    chk("irq_ack_on_expiry", 32'(irq), 32'h0);
    wr(16'hE000, 8'h01);
    for (int k = 0; k < 10; k++) idle(1'b0);
    chk("irq_stall", 32'(irq), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      idle(1'b1);
      if (k >= 4) chk("irq_after_stall", 32'(irq), 32'(k == 5));
    end
    wr(16'hC000, 8'h00);
    wr(16'hE000, 8'h01);
    idle(1'b1);
    chk("irq_latch0_a", 32'(irq), 32'h0);
    idle(1'b1);
    chk("irq_latch0_b", 32'(irq), 32'h1);
    wr(16'hE000, 8'h01);
    idle(1'b1);
    chk("irq_latch0_c", 32'(irq), 32'h0);
    idle(1'b1);
    chk("irq_latch0_d", 32'(irq), 32'h1);
    do_cycle(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 14'h0, 32'h0);
    idle(1'b0);
    chk("irq_reset_no_ce", 32'(irq), 32'h0);

    for (int n = 0; n < 20000; n++) begin
      w = 1'b1;
      d = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0: begin
          a = 16'h6000 | 16'($urandom_range(0, 2047));
          if ($urandom_range(0, 15) != 0) a[8] = 1'b0;
        end
        1: a = 16'h8000 | 16'($urandom_range(0, 16383));
        2: begin
          a = 16'hC000 | 16'($urandom_range(0, 8191));
          if (a[0]) d = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
          else      d = 8'($urandom_range(0, 12));
        end
        3: a = 16'hE000 | 16'($urandom_range(0, 8191));
        default: begin
          a = 16'($urandom_range(0, 65535));
          w = ($urandom_range(0, 3) == 0);
        end
      endcase
      do_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, w, a, d,
               14'($urandom_range(0, 16383)), 32'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
